// File: rtl/multicycle_cpu_param.sv
// Parametrised multi-cycle CPU without an accumulator.
// Five states: FETCH, DECODE, EXECUTE, STORE and HALTED.
// The program is loaded at run time through a write port.
// The register file can be read combinationally through a debug port.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (PC, state, IR, W, flags, register file)
//   run          1 lets FETCH advance, 0 stalls in FETCH
//   imem_we      program-load write enable
//   imem_waddr   program-load address
//   imem_wdata   program-load instruction word {opc[3:0], ra, rb, rd}
//   dbg_raddr    debug register read address
//   dbg_rdata    register file entry at dbg_raddr (combinational)
//   PC           program counter
//   state        FETCH=0, DECODE=1, EXECUTE=2, STORE=3, HALTED=4
//   zflag        zero flag
//   halted       1 while in HALTED
//   illegal      sticky undefined-opcode flag
module multicycle_cpu_param #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IM_AW = 8,
  parameter int unsigned RF_AW = 4,
  localparam int unsigned IW   = 4 + 3 * RF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             imem_we,
  input  logic [IM_AW-1:0] imem_waddr,
  input  logic [IW-1:0]    imem_wdata,
  input  logic [RF_AW-1:0] dbg_raddr,
  output logic [DW-1:0]    dbg_rdata,
  output logic [IM_AW-1:0] PC,
  output logic [2:0]       state,
  output logic             zflag,
  output logic             halted,
  output logic             illegal
);

  localparam int unsigned ImDepth = 2 ** IM_AW;
  localparam int unsigned RfDepth = 2 ** RF_AW;
  localparam logic [DW-1:0] DwLim = DW'(DW);

  localparam logic [3:0] OpHalt = 4'd0;
  localparam logic [3:0] OpLri  = 4'd1;
  localparam logic [3:0] OpMv   = 4'd2;
  localparam logic [3:0] OpAnd  = 4'd3;
  localparam logic [3:0] OpAdd  = 4'd4;
  localparam logic [3:0] OpSub  = 4'd5;
  localparam logic [3:0] OpOr   = 4'd6;
  localparam logic [3:0] OpXor  = 4'd7;
  localparam logic [3:0] OpMvnz = 4'd8;
  localparam logic [3:0] OpShl  = 4'd9;
  localparam logic [3:0] OpShr  = 4'd10;
  localparam logic [3:0] OpJmp  = 4'd11;
  localparam logic [3:0] OpJz   = 4'd12;

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StStore   = 3'd3,
    StHalted  = 3'd4
  } state_e;

  logic [IW-1:0]    imem_q [ImDepth];
  logic [DW-1:0]    rf_q   [RfDepth];

  state_e           state_q, state_d;
  logic [IM_AW-1:0] pc_q, pc_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [DW-1:0]    w_q, w_d;
  logic             zflag_q, zflag_d;
  logic             illegal_q, illegal_d;
  logic             rf_we;

  // Instruction fields; {ra, rb} doubles as the immediate / jump target.
  logic [3:0]         opc;
  logic [RF_AW-1:0]   ra, rb, rd;
  logic [2*RF_AW-1:0] imm;
  logic [DW-1:0]      rf_a, rf_b;
  logic               shift_big;
  logic               sets_z;

  assign opc  = ir_q[IW-1 -: 4];
  assign ra   = ir_q[3*RF_AW-1 -: RF_AW];
  assign rb   = ir_q[2*RF_AW-1 -: RF_AW];
  assign rd   = ir_q[RF_AW-1:0];
  assign imm  = ir_q[3*RF_AW-1:RF_AW];
  assign rf_a = rf_q[ra];
  assign rf_b = rf_q[rb];

  assign shift_big = (rf_b >= DwLim);

  // Only logic/arithmetic results update the zero flag; moves leave it alone.
  always_comb begin
    sets_z = 1'b0;
    case (opc)
      OpAnd, OpAdd, OpSub, OpOr, OpXor, OpShl, OpShr: sets_z = 1'b1;
      default:                                        sets_z = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    w_d       = w_q;
    zflag_d   = zflag_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    case (state_q)
      StFetch: begin
        if (run) begin
          ir_d    = imem_q[pc_q];
          state_d = StDecode;
        end
      end
      StDecode: begin
        pc_d    = pc_q + IM_AW'(1);
        state_d = StExecute;
      end
      StExecute: begin
        state_d = StStore;
        case (opc)
          OpHalt: state_d = StHalted;
          OpLri:  w_d = DW'(imm);
          OpMv:   w_d = rf_a;
          OpAnd:  w_d = rf_a & rf_b;
          OpAdd:  w_d = rf_a + rf_b;
          OpSub:  w_d = rf_a - rf_b;
          OpOr:   w_d = rf_a | rf_b;
          OpXor:  w_d = rf_a ^ rf_b;
          OpMvnz: begin
            if (rf_b != '0) begin
              w_d = rf_a;
            end else begin
              state_d = StFetch;
            end
          end
          OpShl:  w_d = shift_big ? '0 : (rf_a << rf_b);
          OpShr:  w_d = shift_big ? '0 : (rf_a >> rf_b);
          OpJmp: begin
            pc_d    = IM_AW'(imm);
            state_d = StFetch;
          end
          OpJz: begin
            if (zflag_q) begin
              pc_d = IM_AW'(imm);
            end
            state_d = StFetch;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = StHalted;
          end
        endcase
      end
      StStore: begin
        rf_we = 1'b1;
        if (sets_z) begin
          zflag_d = (w_q == '0);
        end
        state_d = StFetch;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= '0;
      ir_q      <= '0;
      w_q       <= '0;
      zflag_q   <= 1'b0;
      illegal_q <= 1'b0;
      for (int unsigned i = 0; i < RfDepth; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      w_q       <= w_d;
      zflag_q   <= zflag_d;
      illegal_q <= illegal_d;
      if (rf_we) begin
        rf_q[rd] <= w_q;
      end
    end
  end

  // Program memory is not cleared by reset; a same-cycle FETCH sees the old word.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_q[imem_waddr] <= imem_wdata;
    end
  end

  assign dbg_rdata = rf_q[dbg_raddr];
  assign PC        = pc_q;
  assign state     = state_q;
  assign zflag     = zflag_q;
  assign halted    = (state_q == StHalted);
  assign illegal   = illegal_q;

endmodule
